if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage; sits directly upstream of the decode stage's IF/ID register.
//  Owns the PC and drives a req/ack instruction-memory port.
//  Produces inst, delay (PC+4) and delay2 (PC+8) for decode.
//  Applies branch/jump/jr redirects with single-delay-slot semantics.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  NOP_INST  32'h0000_0000  encoding driven on inst when no instruction is ready
// PORTS
//  clk           in   1   rising-edge clock
//  rst_n         in   1   async active-low reset
//  stall         in   1   hazard stall from decode; freezes all outputs
//  branch        in   1   taken branch from decode
//  branch_target in   32  branch target (delay + imm<<2)
//  jump          in   1   j/jal from decode
//  jump_target   in   32  absolute jump target
//  jr            in   1   jump-register from decode
//  jr_target     in   32  busA value for jr
//  imem_req      out  1   fetch request
//  imem_addr     out  32  word address; = pc; held stable while imem_req=1
//  imem_ack      in   1   one-cycle acknowledge; imem_rdata valid with it
//  imem_rdata    in   32  fetched instruction
//  inst          out  32  instruction to IF/ID register
//  delay         out  32  PC+4 of inst
//  delay2        out  32  PC+8 of inst
//  fetch_cnt     out  32  instructions delivered (optional feature)
//  stall_cnt     out  32  stall cycles seen (optional feature)
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - pc=RESET_PC, inst=NOP_INST, delay=0, delay2=0, state=IDLE.
//   - pend_v=0, hold_v=0, counters=0, imem_req=0.
//  FSM states IDLE, FETCH, HOLD:
//   - IDLE: one cycle after reset release, then -> FETCH.
//   - FETCH: imem_req=1, imem_addr=pc.
//       ack & !stall: inst<=rdata, delay<=pc+4, delay2<=pc+8, pc<=next_pc; stay in FETCH.
//       ack & stall: rdata/pc+4/pc+8 -> hold buffer, pc<=next_pc, -> HOLD.
//       no ack & !stall: inst<=NOP_INST (bubble); delay/delay2 hold.
//   - HOLD: imem_req=0; outputs frozen; when stall=0, present buffer on outputs, -> FETCH.
//  Zero-wait memory: ack in the same cycle as req is legal. Fetch latency is 1 clk from ack to inst.
//  Stall=1: inst/delay/delay2 hold their values every cycle, so decode re-latches the same instruction.
//  Redirect:
//   - Priority jr > jump > branch; target captured into pend_target, pend_v=1 on the asserting cycle.
//   - next_pc = redirect-this-cycle target, else pend_target if pend_v, else pc+4.
//   - pend_v clears when pc advances.
//   - The in-flight/next-delivered instruction is the delay slot and is always delivered, never squashed.
//  Redirect during stall is captured and applied at the next pc advance.
//  Two redirects before pc advances: the later overwrites (decode guarantees this does not occur).
//  ack while imem_req=0 (HOLD/IDLE, or response to a pre-reset request) is ignored.
//  Reset mid-request: request dropped at once; memory must discard it.
//  PC arithmetic is mod 2^32: 32'hFFFF_FFFC+4 wraps to 0. pc[1:0] are forced 0 on redirect.
// CONFIGURATION
//  IF_PERF_CNT_EN defined:
//   - fetch_cnt increments on each instruction written to inst (FETCH ack & !stall, or HOLD exit).
//   - stall_cnt increments on each cycle with stall=1 while not in IDLE.
//   - Both wrap mod 2^32 and reset to 0.
//  IF_PERF_CNT_EN undefined: fetch_cnt and stall_cnt tied to 0; no counter flops.
// TESTING
//  1. Reset, ack same-cycle always, no stall:
//     inst = mem[0],mem[4],mem[8] on consecutive clks; delay=4,8,12; delay2=8,12,16.
//  2. ack with 2 wait cycles: two NOP_INST bubbles between instructions; imem_addr stable while req=1.
//  3. branch=1, branch_target=0x100 while fetching 0x0C:
//     inst 0x0C (delay slot) delivered, next imem_addr=0x100.
//  4. jr=1 (target 0x40) and branch=1 (0x80) in the same cycle: next fetch 0x40.
//  5. stall=1 for 3 cycles with ack during stall:
//     inst unchanged 3 cycles, FSM in HOLD, req=0; buffered inst appears 1 clk after stall=0.
//  6. rst_n low mid-request, ack pulsed 1 cycle after release:
//     ack ignored, inst=NOP_INST, first fetch at RESET_PC. With IF_PERF_CNT_EN: fetch_cnt=0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a req/ack instruction memory port and
// feeds inst/delay/delay2 to decode. Optional counters built when IF_PERF_CNT_EN is defined.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] delay,
  output logic [31:0] delay2,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_plus8;
  logic [31:0] next_pc;
  logic        pend_v;
  logic [31:0] pend_target;
  logic        redir_v;
  logic [31:0] redir_tgt;
  logic        accept;
  logic        deliver_hold;
  logic        hold_v;
  logic [31:0] hold_inst;
  logic [31:0] hold_delay;
  logic [31:0] hold_delay2;

  // Memory handshake: imem_req is held with imem_addr stable until a single-cycle
  // imem_ack (which may arrive in the same cycle as req) returns imem_rdata; an ack
  // seen while imem_req is low is ignored.
  assign accept       = (state == S_FETCH) && imem_ack;
  assign deliver_hold = (state == S_HOLD) && hold_v && !stall;
  assign pc_plus4     = pc + 32'd4;
  assign pc_plus8     = pc + 32'd8;
  assign imem_addr    = pc;
  assign fsm_state    = state;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: if (imem_ack && stall) state_nxt = S_HOLD;
      S_HOLD:  if (deliver_hold) state_nxt = S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    imem_req = 1'b0;
    case (state)
      S_FETCH: imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
  end

  // Redirect priority jr > jump > branch; targets are forced word-aligned.
  always_comb begin
    redir_v   = jr | jump | branch;
    redir_tgt = branch_target;
    if (jr) begin
      redir_tgt = jr_target;
    end else if (jump) begin
      redir_tgt = jump_target;
    end
    redir_tgt[1:0] = 2'b00;
  end

  always_comb begin
    next_pc = pc_plus4;
    if (redir_v) begin
      next_pc = redir_tgt;
    end else if (pend_v) begin
      next_pc = pend_target;
    end
  end

  // PC and pending redirect; the instruction already in flight is the delay slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      pend_v      <= 1'b0;
      pend_target <= 32'd0;
    end else begin
      if (accept) begin
        pc     <= next_pc;
        pend_v <= 1'b0;
      end else if (redir_v) begin
        pend_v      <= 1'b1;
        pend_target <= redir_tgt;
      end
    end
  end

  // Decode-facing outputs and the buffer used when an ack lands during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst        <= NOP_INST;
      delay       <= 32'd0;
      delay2      <= 32'd0;
      hold_v      <= 1'b0;
      hold_inst   <= 32'd0;
      hold_delay  <= 32'd0;
      hold_delay2 <= 32'd0;
    end else begin
      case (state)
        S_FETCH: begin
          if (accept && !stall) begin
            inst   <= imem_rdata;
            delay  <= pc_plus4;
            delay2 <= pc_plus8;
          end else if (accept) begin
            hold_v      <= 1'b1;
            hold_inst   <= imem_rdata;
            hold_delay  <= pc_plus4;
            hold_delay2 <= pc_plus8;
          end else if (!stall) begin
            inst <= NOP_INST;
          end
        end
        S_HOLD: begin
          if (deliver_hold) begin
            inst   <= hold_inst;
            delay  <= hold_delay;
            delay2 <= hold_delay2;
            hold_v <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if ((accept && !stall) || deliver_hold) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (stall && (state != S_IDLE)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`else
  assign fetch_cnt = 32'd0;
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a memory responder plus a cycle model that
// pushes expected decode outputs into a queue, compared one clock later.
module tb_if_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch, jump, jr, imem_ack;
  logic [31:0] branch_target, jump_target, jr_target, imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr, inst, delay, delay2, fetch_cnt, stall_cnt;
  logic [1:0]  fsm_state;

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .branch(branch), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .jr(jr), .jr_target(jr_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst(inst), .delay(delay), .delay2(delay2),
    .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt), .fsm_state(fsm_state)
  );

  int checks = 0;
  int failures = 0;
  logic [159:0] exp_q[$];

  // Reference model state
  logic        m_req, m_hold, m_pv;
  logic [31:0] m_pc, m_pt, m_fcnt, m_scnt;
  logic [95:0] m_out, m_buf;
  int          wcnt;

  // Stimulus knobs for the next tick
  logic        s_stall, s_branch, s_jump, s_jr, s_force_ack;
  logic [31:0] s_bt, s_jt, s_rt;
  int          wait_n;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE ^ a[31:16], a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_req = 1'b0; m_hold = 1'b0; m_pv = 1'b0;
    m_pc = RESET_PC; m_pt = 32'd0;
    m_out = {NOP, 32'd0, 32'd0}; m_buf = 96'd0;
    m_fcnt = 32'd0; m_scnt = 32'd0; wcnt = 0;
    exp_q.delete();
  endtask

  // One clock: compare last cycle's result, drive inputs, predict, advance to next negedge.
  task automatic tick();
    logic [159:0] e;
    logic         rd, ack, adv;
    logic [31:0]  tgt, nxt;
    logic [1:0]   st;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("inst", inst, e[159:128]);
      check("delay", delay, e[127:96]);
      check("delay2", delay2, e[95:64]);
      check("fetch_cnt", fetch_cnt, e[63:32]);
      check("stall_cnt", stall_cnt, e[31:0]);
    end
    st = m_hold ? 2'd2 : (m_req ? 2'd1 : 2'd0);
    check("fsm_state", {30'd0, fsm_state}, {30'd0, st});
    check("imem_req", {31'd0, imem_req}, {31'd0, m_req});
    if (m_req) check("imem_addr", imem_addr, m_pc);

    ack = (m_req && (wcnt >= wait_n)) || s_force_ack;
    stall = s_stall; branch = s_branch; jump = s_jump; jr = s_jr;
    branch_target = s_bt; jump_target = s_jt; jr_target = s_rt;
    imem_ack = ack;
    imem_rdata = ack ? mem_word(m_pc) : 32'hBAD0_BAD0;

    rd  = s_jr | s_jump | s_branch;
    tgt = s_jr ? s_rt : (s_jump ? s_jt : s_bt);
    tgt[1:0] = 2'b00;
    adv = m_req && ack;
    if (s_stall && (m_req || m_hold)) m_scnt++;
    if (m_hold) begin
      if (!s_stall) begin
        m_out = m_buf; m_fcnt++; m_hold = 1'b0; m_req = 1'b1;
      end
    end else if (adv) begin
      nxt = rd ? tgt : (m_pv ? m_pt : m_pc + 32'd4);
      if (!s_stall) begin
        m_out = {mem_word(m_pc), m_pc + 32'd4, m_pc + 32'd8}; m_fcnt++;
      end else begin
        m_buf = {mem_word(m_pc), m_pc + 32'd4, m_pc + 32'd8}; m_hold = 1'b1; m_req = 1'b0;
      end
      m_pc = nxt; wcnt = 0;
    end else if (m_req) begin
      if (!s_stall) m_out[95:64] = NOP;
      wcnt++;
    end else begin
      m_req = 1'b1;
    end
    if (adv) m_pv = 1'b0;
    else if (rd) begin m_pv = 1'b1; m_pt = tgt; end
`ifdef IF_PERF_CNT_EN
    exp_q.push_back({m_out, m_fcnt, m_scnt});
`else
    exp_q.push_back({m_out, 64'd0});
`endif
    s_branch = 1'b0; s_jump = 1'b0; s_jr = 1'b0; s_force_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; stall = 0; branch = 0; jump = 0; jr = 0; imem_ack = 0;
    branch_target = 0; jump_target = 0; jr_target = 0; imem_rdata = 0;
    s_stall = 0; s_branch = 0; s_jump = 0; s_jr = 0; s_force_ack = 0;
    s_bt = 0; s_jt = 0; s_rt = 0; wait_n = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_inst", inst, NOP);
    check("rst_delay", delay, 32'd0);
    check("rst_delay2", delay2, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_fetch_cnt", fetch_cnt, 32'd0);
    rst_n = 1'b1;

    // Zero-wait streaming from RESET_PC
    wait_n = 0;
    repeat (6) tick();
    // Two wait cycles per fetch: bubbles and stable address
    wait_n = 2;
    repeat (10) tick();
    // Taken branch, delay slot still delivered
    wait_n = 0;
    tick();
    s_branch = 1'b1; s_bt = 32'h0000_0100;
    tick();
    check("branch_addr", imem_addr, 32'h0000_0100);
    repeat (3) tick();
    // jr beats branch in the same cycle
    s_jr = 1'b1; s_rt = 32'h0000_0040; s_branch = 1'b1; s_bt = 32'h0000_0080;
    tick();
    check("jr_prio_addr", imem_addr, 32'h0000_0040);
    repeat (2) tick();
    // Redirect while waiting on memory is held pending
    wait_n = 2;
    tick();
    s_jump = 1'b1; s_jt = 32'h0000_0300;
    repeat (6) tick();
    // Unaligned jump target and PC wrap
    wait_n = 0;
    s_jump = 1'b1; s_jt = 32'hFFFF_FFFF;
    tick();
    check("align_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_addr", imem_addr, 32'h0000_0000);
    repeat (2) tick();
    // Stall for 3 cycles with ack inside the stall
    s_stall = 1'b1;
    repeat (3) tick();
    s_stall = 1'b0;
    repeat (3) tick();
    // Redirect captured during HOLD applies at the next advance
    s_stall = 1'b1;
    tick();
    s_branch = 1'b1; s_bt = 32'h0000_0200;
    tick();
    s_stall = 1'b0;
    tick();
    tick();
    check("hold_redir_addr", imem_addr, 32'h0000_0200);
    repeat (2) tick();
    // Stall over a waiting request
    wait_n = 2;
    s_stall = 1'b1;
    repeat (5) tick();
    s_stall = 1'b0;
    repeat (6) tick();
    // Randomised stalls and wait states
    for (int i = 0; i < 40; i++) begin
      s_stall = ($urandom_range(0, 3) == 0);
      wait_n = $urandom_range(0, 2);
      if ($urandom_range(0, 9) == 0) begin
        s_branch = 1'b1; s_bt = $urandom_range(0, 255) * 4;
      end
      tick();
    end
    s_stall = 1'b0;
    repeat (4) tick();

    // Reset in the middle of an outstanding request
    wait_n = 3;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_req", {31'd0, imem_req}, 32'd0);
    check("midrst_inst", inst, NOP);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    s_force_ack = 1'b1;
    tick();
    tick();
    check("post_rst_addr", imem_addr, RESET_PC);
    check("post_rst_fetch_cnt", fetch_cnt, 32'd0);
    wait_n = 0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
